// File: rtl/fabric_config_loader_pkg.sv
// fabric_config_pkg: shared constants and FSM state type for the fabric configuration loader
package fabric_config_pkg;
    localparam int NUM_LUT_GRP = 6;
    localparam int NUM_SB_GRP  = 3;
    localparam int WORD_W      = 32;
    localparam int IMAGE_WORDS = 2 * NUM_LUT_GRP + NUM_SB_GRP + 1;
    localparam logic [3:0] GRP_ADD0 = 4'd0;
    localparam logic [3:0] GRP_ADD1 = 4'd1;
    localparam logic [3:0] GRP_ADDC = 4'd2;
    localparam logic [3:0] GRP_MUX  = 4'd3;
    localparam logic [3:0] GRP_MUXS = 4'd4;
    localparam logic [3:0] GRP_REGC = 4'd5;
    localparam logic [3:0] SB_0     = 4'd0;
    localparam logic [3:0] SB_12    = 4'd1;
    localparam logic [3:0] SB_3     = 4'd2;
    typedef enum logic [2:0] {IDLE, LUT_WORD, MUX_WORD, SB_WORD, CHECK, DONE, ERROR} state_e;
endpackage

// File: rtl/fabric_config_loader_if.sv
// fabric_config_loader_if: host word stream plus fabric group write bus
interface fabric_config_loader_if;
    import fabric_config_pkg::*;
    logic              start, in_valid, in_ready;
    logic [WORD_W-1:0] in_data;
    logic [3:0]        cfg_sel;
    logic [WORD_W:0]   cfg_lut_data;
    logic              cfg_lut_we, cfg_sb_we;
    logic [15:0]       cfg_sb_data;
    logic              fabric_en, busy, done, error;
    modport master (output start, in_data, in_valid,
                    input in_ready, cfg_sel, cfg_lut_data, cfg_lut_we, cfg_sb_data, cfg_sb_we,
                          fabric_en, busy, done, error);
    modport slave  (input start, in_data, in_valid,
                    output in_ready, cfg_sel, cfg_lut_data, cfg_lut_we, cfg_sb_data, cfg_sb_we,
                           fabric_en, busy, done, error);
endinterface

// File: rtl/fabric_config_loader_cfg_xor_accum.sv
// cfg_xor_accum: clearable XOR accumulator with registered output
module cfg_xor_accum #(
    parameter int WORD_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] q_o
);
    logic [WORD_W-1:0] acc_q;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) acc_q <= '0;
        else if (clr_i) acc_q <= '0;
        else if (en_i) acc_q <= acc_q ^ d_i;
    end
    assign q_o = acc_q;
endmodule

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams a 16-word image into fabric LUT/SB groups,
// verifies the XOR checksum and releases the fabric on success
module fabric_config_loader
    import fabric_config_pkg::*;
(
    input logic clock_i,
    input logic reset_n_i,
    fabric_config_loader_if.slave bus
);
    state_e            state_q, state_d;
    logic [3:0]        grp_q, grp_d, sel_q, sel_d;
    logic [WORD_W-1:0] lut_buf_q, lut_buf_d, chk;
    logic [WORD_W:0]   lut_data_q, lut_data_d;
    logic [15:0]       sb_data_q, sb_data_d;
    logic              lut_we_q, lut_we_d, sb_we_q, sb_we_d;
    logic              en_q, en_d, done_q, done_d, err_q, err_d;
    logic              chk_clr, chk_en, xfer, lut_last, sb_last;

    assign bus.in_ready = state_q inside {LUT_WORD, MUX_WORD, SB_WORD, CHECK};
    assign xfer         = bus.in_valid && bus.in_ready;
    assign lut_last     = grp_q == 4'(NUM_LUT_GRP - 1);
    assign sb_last      = grp_q == 4'(NUM_SB_GRP - 1);

    cfg_xor_accum #(.WORD_W(WORD_W)) u_chk (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .clr_i(chk_clr), .en_i(chk_en),
        .d_i(bus.in_data), .q_o(chk)
    );

    always_comb begin
        state_d = state_q; grp_d = grp_q; lut_buf_d = lut_buf_q;
        sel_d = sel_q; lut_data_d = lut_data_q; sb_data_d = sb_data_q;
        lut_we_d = 1'b0; sb_we_d = 1'b0;
        en_d = en_q; done_d = done_q; err_d = err_q;
        chk_clr = 1'b0; chk_en = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: if (bus.start) begin
                state_d = LUT_WORD; grp_d = '0; chk_clr = 1'b1;
                en_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
            end
            LUT_WORD: if (xfer) begin
                lut_buf_d = bus.in_data; chk_en = 1'b1; state_d = MUX_WORD;
            end
            MUX_WORD: if (xfer) begin
                chk_en = 1'b1; lut_we_d = 1'b1; sel_d = grp_q;
                lut_data_d = {bus.in_data[0], lut_buf_q};
                grp_d = lut_last ? 4'd0 : grp_q + 4'd1;
                state_d = lut_last ? SB_WORD : LUT_WORD;
            end
            SB_WORD: if (xfer) begin
                chk_en = 1'b1; sb_we_d = 1'b1; sel_d = grp_q;
                sb_data_d = bus.in_data[15:0];
                grp_d = sb_last ? 4'd0 : grp_q + 4'd1;
                state_d = sb_last ? CHECK : SB_WORD;
            end
            CHECK: if (xfer) begin
                done_d = bus.in_data == chk;
                err_d = bus.in_data != chk;
                en_d = bus.in_data == chk;
                state_d = bus.in_data == chk ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE; grp_q <= '0; lut_buf_q <= '0;
            sel_q <= '0; lut_data_q <= '0; sb_data_q <= '0;
            lut_we_q <= 1'b0; sb_we_q <= 1'b0;
            en_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
        end else begin
            state_q <= state_d; grp_q <= grp_d; lut_buf_q <= lut_buf_d;
            sel_q <= sel_d; lut_data_q <= lut_data_d; sb_data_q <= sb_data_d;
            lut_we_q <= lut_we_d; sb_we_q <= sb_we_d;
            en_q <= en_d; done_q <= done_d; err_q <= err_d;
        end
    end

    assign bus.cfg_sel      = sel_q;
    assign bus.cfg_lut_data = lut_data_q;
    assign bus.cfg_lut_we   = lut_we_q;
    assign bus.cfg_sb_data  = sb_data_q;
    assign bus.cfg_sb_we    = sb_we_q;
    assign bus.fabric_en    = en_q;
    assign bus.busy         = bus.in_ready;
    assign bus.done         = done_q;
    assign bus.error        = err_q;
endmodule

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: directed scenario tests for the fabric configuration loader
module tb_fabric_config_loader;
    import fabric_config_pkg::*;
    logic clock_i = 1'b0;
    logic reset_n_i = 1'b0;
    fabric_config_loader_if bus();
    fabric_config_loader dut (.clock_i(clock_i), .reset_n_i(reset_n_i), .bus(bus));
    always #5 clock_i = ~clock_i;

    int vectors = 0, miscompares = 0, cyc = 0, overlap = 0;
    logic [31:0] img [16];
    int          acc_cyc[$], w_cyc[$];
    bit          w_lut[$];
    logic [3:0]  w_sel[$];
    logic [32:0] w_data[$];

    // Inputs change at posedge+1, so the negedge sees a settled bus.
    always @(negedge clock_i) begin
        cyc++;
        if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (bus.cfg_lut_we) begin
            w_lut.push_back(1'b1); w_sel.push_back(bus.cfg_sel);
            w_data.push_back(bus.cfg_lut_data); w_cyc.push_back(cyc);
        end
        if (bus.cfg_sb_we) begin
            w_lut.push_back(1'b0); w_sel.push_back(bus.cfg_sel);
            w_data.push_back({17'd0, bus.cfg_sb_data}); w_cyc.push_back(cyc);
        end
        if (bus.cfg_lut_we && bus.cfg_sb_we) overlap++;
    end

    function automatic logic [32:0] exp_data(int i);
        return i < 6 ? {img[2*i+1][0], img[2*i]} : {17'd0, img[i+6][15:0]};
    endfunction
    function automatic logic [3:0] exp_sel(int i);
        return 4'(i < 6 ? i : i - 6);
    endfunction
    function automatic int exp_acc(int i);
        return i < 6 ? 2 * i + 1 : i + 6;
    endfunction

    task automatic make_image();
        for (int k = 0; k < 15; k++) img[k] = 32'(k + 1);
    endtask
    task automatic fix_chk();
        img[15] = '0;
        for (int k = 0; k < 15; k++) img[15] ^= img[k];
    endtask
    task automatic clear_log();
        acc_cyc.delete(); w_cyc.delete(); w_lut.delete(); w_sel.delete(); w_data.delete();
    endtask
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clock_i); #1;
        bus.start = 1'b0;
    endtask
    task automatic send(input logic [31:0] w, input int gap);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clock_i); #1; end
        bus.in_data = w; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clock_i); #1; n++; end
        vectors++;
        if (!bus.in_ready) begin
            miscompares++;
            $display("FAIL send_timeout word=%h in_ready=%b need 1", w, bus.in_ready);
        end
        @(posedge clock_i); #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic load(input int gap);
        clear_log();
        pulse_start();
        for (int k = 0; k < 16; k++) send(img[k], gap);
        @(posedge clock_i); #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({bus.in_ready, bus.cfg_sel, bus.cfg_lut_data, bus.cfg_lut_we, bus.cfg_sb_data, bus.cfg_sb_we,
             bus.fabric_en, bus.busy, bus.done, bus.error} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got nonzero outputs, need all 0");
        end
        @(posedge clock_i); #1;
        reset_n_i = 1'b1;
        @(posedge clock_i); #1;
        vectors++;
        if ({bus.busy, bus.done, bus.fabric_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle got busy/done/en=%b need 000", {bus.busy, bus.done, bus.fabric_en});
        end
    endtask

    task automatic test_good_load();
        make_image(); fix_chk();
        load(0);
        vectors++;
        if (w_data.size() != 9) begin
            miscompares++; $display("FAIL good_count got %0d writes need 9", w_data.size());
        end
        for (int i = 0; i < 9 && i < w_data.size(); i++) begin
            vectors++;
            if (w_lut[i] !== (i < 6) || w_sel[i] !== exp_sel(i) || w_data[i] !== exp_data(i) ||
                w_cyc[i] !== acc_cyc[exp_acc(i)] + 1) begin
                miscompares++;
                $display("FAIL good_write%0d got lut=%0b sel=%0d data=%h cyc=%0d need lut=%0b sel=%0d data=%h cyc=%0d",
                         i, w_lut[i], w_sel[i], w_data[i], w_cyc[i], i < 6, exp_sel(i), exp_data(i), acc_cyc[exp_acc(i)] + 1);
            end
        end
        vectors++;
        if (w_data.size() > 1 && (w_data[0] !== 33'h0_00000001 || w_data[1] !== 33'h0_00000003)) begin
            miscompares++; $display("FAIL good_lut01 got %h %h need 000000001 000000003", w_data[0], w_data[1]);
        end
        vectors++;
        if ({bus.done, bus.fabric_en, bus.busy, bus.error} !== 4'b1100) begin
            miscompares++;
            $display("FAIL good_status got done/en/busy/err=%b need 1100", {bus.done, bus.fabric_en, bus.busy, bus.error});
        end
        vectors++;
        if (overlap != 0) begin
            miscompares++; $display("FAIL good_overlap got %0d need 0", overlap);
        end
    endtask

    task automatic test_bad_checksum();
        make_image(); img[15] = 32'h1;
        load(0);
        vectors++;
        if (w_data.size() != 9) begin
            miscompares++; $display("FAIL bad_count got %0d writes need 9", w_data.size());
        end
        for (int i = 0; i < 9 && i < w_data.size(); i++) begin
            vectors++;
            if (w_sel[i] !== exp_sel(i) || w_data[i] !== exp_data(i)) begin
                miscompares++;
                $display("FAIL bad_write%0d got sel=%0d data=%h need sel=%0d data=%h", i, w_sel[i], w_data[i], exp_sel(i), exp_data(i));
            end
        end
        vectors++;
        if ({bus.error, bus.done, bus.fabric_en, bus.busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL bad_status got err/done/en/busy=%b need 1000", {bus.error, bus.done, bus.fabric_en, bus.busy});
        end
    endtask

    task automatic test_backpressure();
        make_image(); fix_chk();
        load(2);
        vectors++;
        if (w_data.size() != 9 || acc_cyc.size() != 16) begin
            miscompares++;
            $display("FAIL bp_count got %0d writes %0d accepts need 9 16", w_data.size(), acc_cyc.size());
        end
        for (int i = 0; i < 9 && i < w_data.size(); i++) begin
            vectors++;
            if (w_sel[i] !== exp_sel(i) || w_data[i] !== exp_data(i) || w_cyc[i] !== acc_cyc[exp_acc(i)] + 1) begin
                miscompares++;
                $display("FAIL bp_write%0d got sel=%0d data=%h cyc=%0d need sel=%0d data=%h cyc=%0d",
                         i, w_sel[i], w_data[i], w_cyc[i], exp_sel(i), exp_data(i), acc_cyc[exp_acc(i)] + 1);
            end
        end
        vectors++;
        if ({bus.done, bus.fabric_en} !== 2'b11) begin
            miscompares++; $display("FAIL bp_status got done/en=%b need 11", {bus.done, bus.fabric_en});
        end
    endtask

    task automatic test_mux_bit();
        make_image(); img[5] = 32'hFFFF_FFFE; img[7] = 32'h0000_0001; fix_chk();
        load(0);
        vectors++;
        if (w_data.size() != 9) begin
            miscompares++; $display("FAIL mux_count got %0d writes need 9", w_data.size());
        end else if (w_data[2][32] !== 1'b0 || w_data[3][32] !== 1'b1 ||
                     w_data[2] !== {1'b0, img[4]} || w_data[3] !== {1'b1, img[6]}) begin
            miscompares++;
            $display("FAIL mux_bit got g2=%h g3=%h need %h %h", w_data[2], w_data[3], {1'b0, img[4]}, {1'b1, img[6]});
        end
        vectors++;
        if ({bus.done, bus.error} !== 2'b10) begin
            miscompares++; $display("FAIL mux_chk got done/err=%b need 10", {bus.done, bus.error});
        end
    endtask

    task automatic test_restart();
        make_image(); fix_chk();
        clear_log();
        pulse_start();
        for (int k = 0; k < 7; k++) send(img[k], 0);
        pulse_start();
        for (int k = 7; k < 16; k++) send(img[k], 0);
        @(posedge clock_i); #1;
        vectors++;
        if (w_data.size() != 9 || acc_cyc.size() != 16) begin
            miscompares++;
            $display("FAIL restart_count got %0d writes %0d accepts need 9 16", w_data.size(), acc_cyc.size());
        end
        for (int i = 0; i < 9 && i < w_data.size(); i++) begin
            vectors++;
            if (w_sel[i] !== exp_sel(i) || w_data[i] !== exp_data(i)) begin
                miscompares++;
                $display("FAIL restart_write%0d got sel=%0d data=%h need sel=%0d data=%h", i, w_sel[i], w_data[i], exp_sel(i), exp_data(i));
            end
        end
        vectors++;
        if ({bus.done, bus.fabric_en} !== 2'b11) begin
            miscompares++; $display("FAIL restart_done got done/en=%b need 11", {bus.done, bus.fabric_en});
        end
        pulse_start();
        vectors++;
        if ({bus.done, bus.fabric_en, bus.busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL restart_drop got done/en/busy=%b need 001", {bus.done, bus.fabric_en, bus.busy});
        end
        for (int k = 0; k < 16; k++) send(img[k], 0);
        @(posedge clock_i); #1;
        vectors++;
        if ({bus.done, bus.fabric_en, bus.busy} !== 3'b110) begin
            miscompares++;
            $display("FAIL restart_reload got done/en/busy=%b need 110", {bus.done, bus.fabric_en, bus.busy});
        end
    endtask

    task automatic test_reset_mid_load();
        make_image(); fix_chk();
        clear_log();
        pulse_start();
        for (int k = 0; k < 6; k++) send(img[k], 0);
        #1 reset_n_i = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.cfg_sel, bus.cfg_lut_data, bus.cfg_lut_we, bus.cfg_sb_data, bus.cfg_sb_we,
             bus.fabric_en, bus.busy, bus.done, bus.error} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got lut_we=%b busy=%b sel=%0d, need all 0", bus.cfg_lut_we, bus.busy, bus.cfg_sel);
        end
        @(posedge clock_i); #1;
        reset_n_i = 1'b1;
        @(posedge clock_i); #1;
        load(0);
        vectors++;
        if (w_data.size() != 9 || {bus.done, bus.fabric_en, bus.error} !== 3'b110) begin
            miscompares++;
            $display("FAIL midreset_reload got writes=%0d done/en/err=%b need 9 110", w_data.size(), {bus.done, bus.fabric_en, bus.error});
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_backpressure();
        test_mux_bit();
        test_restart();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
